// File: rtl/uart_rx_controller.sv
// UART receive controller: sequences the RX datapath through one frame
// (start, 8 data bits LSB-first, optional parity, one or two stop bits),
// hands good bytes to the RX FIFO and raises one-cycle error pulses.
module uart_rx_controller (
    input  logic clk,
    input  logic reset,
    input  logic baud_x16_tick,
    input  logic rx_enable,
    input  logic parity_en,
    input  logic stop_bits_two,
    input  logic rd_req,
    input  logic rx_sync,
    input  logic rx_sync_fall,
    input  logic rx_get_sample,
    input  logic rx_bits_cnt_top,
    input  logic rx_parity_out,
    input  logic rx_error_reg_out,
    input  logic rx_queue_full,
    input  logic rx_queue_empty,
    output logic rx_sync_en,
    output logic rx_sample_reg_we,
    output logic rx_sample_reg_reset,
    output logic rx_parity_we,
    output logic rx_parity_reset,
    output logic rx_bits_cnt_en,
    output logic rx_bits_cnt_reset,
    output logic rx_sample_cnt_en,
    output logic rx_sample_cnt_reset,
    output logic rx_error_reg_set,
    output logic rx_error_reg_reset,
    output logic rx_queue_we,
    output logic rx_queue_re,
    output logic frame_err,
    output logic parity_err,
    output logic overrun_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_STORE  = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_sample;
    logic w_frame_err_set;
    logic w_parity_err_set;
    logic w_overrun_err_set;
    logic r_frame_err;
    logic r_parity_err;
    logic r_overrun_err;

    // Mid-bit sampling point: exactly one clk per bit period.
    assign w_sample = baud_x16_tick & rx_get_sample;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and combinational datapath controls.
    always_comb begin
        w_next_state        = r_state;
        rx_sync_en          = 1'b1;
        rx_sample_reg_we    = 1'b0;
        rx_sample_reg_reset = 1'b0;
        rx_parity_we        = 1'b0;
        rx_parity_reset     = 1'b0;
        rx_bits_cnt_en      = 1'b0;
        rx_bits_cnt_reset   = 1'b0;
        rx_sample_cnt_en    = (r_state != S_IDLE) ? baud_x16_tick : 1'b0;
        rx_sample_cnt_reset = 1'b0;
        rx_error_reg_set    = 1'b0;
        rx_error_reg_reset  = 1'b0;
        rx_queue_we         = 1'b0;
        rx_queue_re         = rd_req & ~rx_queue_empty;
        w_frame_err_set     = 1'b0;
        w_parity_err_set    = 1'b0;
        w_overrun_err_set   = 1'b0;

        if ((r_state != S_IDLE) && !rx_enable) begin
            // Receiver disabled mid-frame: abandon silently.
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    rx_sample_cnt_reset = 1'b1;
                    rx_bits_cnt_reset   = 1'b1;
                    rx_parity_reset     = 1'b1;
                    rx_sample_reg_reset = 1'b1;
                    rx_error_reg_reset  = 1'b1;
                    if (rx_enable && rx_sync_fall) begin
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        // A line back high at mid-start was only a glitch.
                        w_next_state = rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        w_next_state = S_START;
                    end
                end
                S_DATA: begin
                    if (rx_bits_cnt_top) begin
                        w_next_state = parity_en ? S_PARITY : S_STOP1;
                    end else if (w_sample) begin
                        rx_sample_reg_we = 1'b1;
                        rx_parity_we     = 1'b1;
                        rx_bits_cnt_en   = 1'b1;
                        w_next_state     = S_DATA;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        rx_error_reg_set = (rx_sync != rx_parity_out);
                        w_next_state     = S_STOP1;
                    end else begin
                        w_next_state = S_PARITY;
                    end
                end
                S_STOP1: begin
                    if (w_sample) begin
                        if (!rx_sync) begin
                            w_frame_err_set = 1'b1;
                            w_next_state    = S_IDLE;
                        end else if (stop_bits_two) begin
                            w_next_state = S_STOP2;
                        end else begin
                            w_next_state = S_STORE;
                        end
                    end else begin
                        w_next_state = S_STOP1;
                    end
                end
                S_STOP2: begin
                    if (w_sample) begin
                        if (!rx_sync) begin
                            w_frame_err_set = 1'b1;
                            w_next_state    = S_IDLE;
                        end else begin
                            w_next_state = S_STORE;
                        end
                    end else begin
                        w_next_state = S_STOP2;
                    end
                end
                S_STORE: begin
                    w_next_state = S_IDLE;
                    if (rx_error_reg_out) begin
                        w_parity_err_set = 1'b1;
                    end else if (rx_queue_full) begin
                        w_overrun_err_set = 1'b1;
                    end else begin
                        rx_queue_we = 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Error pulse registers: each set term lasts one clk, so each pulse does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_frame_err_set;
            r_parity_err  <= w_parity_err_set;
            r_overrun_err <= w_overrun_err_set;
        end
    end

    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: surrounds the controller with a behavioural
// RX datapath (synchronizer, counters, shift register, even parity, error
// register, 16-deep FIFO) and checks received bytes through a scoreboard.
module tb_uart_rx_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, baud_x16_tick, rx_enable, parity_en, stop_bits_two, rd_req, rx_line;
    logic rx_sync, rx_sync_fall, rx_get_sample, rx_bits_cnt_top, rx_parity_out;
    logic rx_error_reg_out, rx_queue_full, rx_queue_empty;
    logic rx_sync_en, rx_sample_reg_we, rx_sample_reg_reset, rx_parity_we, rx_parity_reset;
    logic rx_bits_cnt_en, rx_bits_cnt_reset, rx_sample_cnt_en, rx_sample_cnt_reset;
    logic rx_error_reg_set, rx_error_reg_reset, rx_queue_we, rx_queue_re;
    logic frame_err, parity_err, overrun_err;

    uart_rx_controller dut (
        .clk(clk), .reset(reset), .baud_x16_tick(baud_x16_tick), .rx_enable(rx_enable),
        .parity_en(parity_en), .stop_bits_two(stop_bits_two), .rd_req(rd_req),
        .rx_sync(rx_sync), .rx_sync_fall(rx_sync_fall), .rx_get_sample(rx_get_sample),
        .rx_bits_cnt_top(rx_bits_cnt_top), .rx_parity_out(rx_parity_out),
        .rx_error_reg_out(rx_error_reg_out), .rx_queue_full(rx_queue_full),
        .rx_queue_empty(rx_queue_empty), .rx_sync_en(rx_sync_en),
        .rx_sample_reg_we(rx_sample_reg_we), .rx_sample_reg_reset(rx_sample_reg_reset),
        .rx_parity_we(rx_parity_we), .rx_parity_reset(rx_parity_reset),
        .rx_bits_cnt_en(rx_bits_cnt_en), .rx_bits_cnt_reset(rx_bits_cnt_reset),
        .rx_sample_cnt_en(rx_sample_cnt_en), .rx_sample_cnt_reset(rx_sample_cnt_reset),
        .rx_error_reg_set(rx_error_reg_set), .rx_error_reg_reset(rx_error_reg_reset),
        .rx_queue_we(rx_queue_we), .rx_queue_re(rx_queue_re),
        .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
    );

    // ---------------- behavioural datapath ----------------
    logic       r_sync, r_sync_d, r_par, r_err;
    logic [3:0] r_scnt, r_bcnt;
    logic [7:0] r_sreg, pop_data;
    logic [4:0] fifo_level;
    logic [7:0] fifo_q[$];

    assign rx_sync          = r_sync;
    assign rx_sync_fall     = r_sync_d & ~r_sync;
    assign rx_get_sample    = (r_scnt == 4'd7);
    assign rx_bits_cnt_top  = (r_bcnt == 4'd8);
    assign rx_parity_out    = r_par;
    assign rx_error_reg_out = r_err;
    assign rx_queue_full    = (fifo_level == 5'd16);
    assign rx_queue_empty   = (fifo_level == 5'd0);

    // Datapath registers driven by the controller's enables and resets.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 1'b1; r_sync_d <= 1'b1; r_scnt <= 4'd0; r_bcnt <= 4'd0;
            r_sreg <= 8'd0; r_par <= 1'b0; r_err <= 1'b0;
        end else begin
            if (rx_sync_en) begin
                r_sync   <= rx_line;
                r_sync_d <= r_sync;
            end
            if (rx_sample_cnt_reset) r_scnt <= 4'd0;
            else if (rx_sample_cnt_en) r_scnt <= r_scnt + 4'd1;
            if (rx_bits_cnt_reset) r_bcnt <= 4'd0;
            else if (rx_bits_cnt_en) r_bcnt <= r_bcnt + 4'd1;
            if (rx_sample_reg_reset) r_sreg <= 8'd0;
            else if (rx_sample_reg_we) r_sreg <= {r_sync, r_sreg[7:1]};
            if (rx_parity_reset) r_par <= 1'b0;
            else if (rx_parity_we) r_par <= r_par ^ r_sync;
            if (rx_error_reg_reset) r_err <= 1'b0;
            else if (rx_error_reg_set) r_err <= 1'b1;
        end
    end

    // FIFO model: a pop and a push may share one cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q.delete();
            fifo_level <= 5'd0;
            pop_data   <= 8'd0;
        end else begin
            if (rx_queue_re && fifo_q.size() > 0) pop_data <= fifo_q.pop_front();
            if (rx_queue_we && fifo_q.size() < 16) fifo_q.push_back(r_sreg);
            fifo_level <= fifo_level + ((rx_queue_we && !rx_queue_full) ? 5'd1 : 5'd0)
                                     - (rx_queue_re ? 5'd1 : 5'd0);
        end
    end

    // Event monitors.
    int we_cnt = 0, ferr_cnt = 0, perr_cnt = 0, oerr_cnt = 0, multi_cnt = 0, busy_cnt = 0;
    always @(posedge clk) begin
        if (rx_queue_we) we_cnt <= we_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (overrun_err) oerr_cnt <= oerr_cnt + 1;
        if ((32'(frame_err) + 32'(parity_err) + 32'(overrun_err)) > 32'd1) multi_cnt <= multi_cnt + 1;
        if (!rx_sample_cnt_reset) busy_cnt <= busy_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0, n_err = 0;
    int we0, f0, p0, o0, b0;
    logic drop_idle;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        we0 = we_cnt; f0 = ferr_cnt; p0 = perr_cnt; o0 = oerr_cnt; b0 = busy_cnt;
    endtask

    task automatic check_events(input string tag, input int we_d, input int f_d, input int p_d, input int o_d);
        check({tag, "_we"},      32'(we_cnt - we0),  32'(we_d));
        check({tag, "_frame"},   32'(ferr_cnt - f0), 32'(f_d));
        check({tag, "_parity"},  32'(perr_cnt - p0), 32'(p_d));
        check({tag, "_overrun"}, 32'(oerr_cnt - o0), 32'(o_d));
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            check(tag, 32'(pop_data), 32'(e));
        end
    endtask

    // Drive one frame, 16 clks per bit; stop_v is the level of the last stop bit.
    task automatic send_frame(input logic [7:0] d, input logic p_en, input logic p_bit,
                              input int nstop, input logic stop_v, input logic end_v,
                              input int drop_off, input logic rd_store);
        logic bits[$];
        int off;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (p_en) bits.push_back(p_bit);
        for (int i = 1; i < nstop; i++) bits.push_back(1'b1);
        bits.push_back(stop_v);
        off = 0;
        foreach (bits[k]) begin
            rx_line = bits[k];
            for (int j = 0; j < 16; j++) begin
                if (off == drop_off) rx_enable = 1'b0;
                if (off == drop_off + 1) drop_idle = rx_sample_cnt_reset;
                if (rd_store) rd_req = (off == 154);
                @(negedge clk);
                off++;
            end
        end
        rx_line = end_v;
        rd_req = 1'b0;
        rx_enable = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; baud_x16_tick = 1'b1; rx_enable = 1'b1; parity_en = 1'b0;
        stop_bits_two = 1'b0; rd_req = 1'b0; rx_line = 1'b1; drop_idle = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        check("rst_idle_resets", 32'({rx_sample_cnt_reset, rx_bits_cnt_reset, rx_error_reg_reset}), 32'h7);
        check("rst_sync_en", 32'(rx_sync_en), 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 frame 0xA5
        snap(); exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1, -100, 1'b0);
        check_events("a5", 1, 0, 0, 0);
        pop_check("a5_pop");
        check("a5_empty", 32'(rx_queue_empty), 32'd1);

        // 8E1, wrong parity on 0x3C, then correct parity
        parity_en = 1'b1;
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b1, -100, 1'b0);
        check_events("par_bad", 0, 0, 1, 0);
        snap(); exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b1, 1'b1, -100, 1'b0);
        check_events("par_ok", 1, 0, 0, 0);
        pop_check("par_ok_pop");
        parity_en = 1'b0;

        // 8N2 frames: good, then bad second stop bit
        stop_bits_two = 1'b1;
        snap(); exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0, 1'b0, 2, 1'b1, 1'b1, -100, 1'b0);
        check_events("two_stop", 1, 0, 0, 0);
        pop_check("two_stop_pop");
        snap();
        send_frame(8'h69, 1'b0, 1'b0, 2, 1'b0, 1'b1, -100, 1'b0);
        check_events("stop2_bad", 0, 1, 0, 0);
        stop_bits_two = 1'b0;

        // 0x55 with stop bit 0, line held low (break)
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0, -100, 1'b0);
        check_events("brk", 0, 1, 0, 0);
        check("brk_idle", 32'(rx_sample_cnt_reset), 32'd1);
        snap();
        repeat (100) @(negedge clk);
        check("brk_no_retrigger", 32'(busy_cnt - b0), 32'd0);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);

        // 2-clk glitch: START for 8 clks then back to IDLE
        snap();
        rx_line = 1'b0;
        repeat (2) @(negedge clk);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_start_len", 32'(busy_cnt - b0), 32'd8);
        check_events("glitch", 0, 0, 0, 0);

        // Fill the FIFO, then overrun with and without a read in STORE
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(8'h10 + 8'(i * 7));
            exp_q.push_back(b);
            send_frame(b, 1'b0, 1'b0, 1, 1'b1, 1'b1, -100, 1'b0);
        end
        check("fill_full", 32'(rx_queue_full), 32'd1);
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b1, -100, 1'b0);
        check_events("ovr", 0, 0, 0, 1);
        check("ovr_level", 32'(fifo_level), 32'd16);
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b1, -100, 1'b1);
        check_events("ovr_rd", 0, 0, 0, 1);
        check("ovr_rd_level", 32'(fifo_level), 32'd15);
        if (exp_q.size() > 0) check("ovr_rd_pop", 32'(pop_data), 32'(exp_q.pop_front()));
        for (int i = 0; i < 15; i++) pop_check("drain_pop");
        check("drain_empty", 32'(rx_queue_empty), 32'd1);

        // rx_enable dropped during data bit 3, then a good 0x0F
        snap();
        send_frame(8'hC3, 1'b0, 1'b0, 1, 1'b1, 1'b1, 70, 1'b0);
        check("drop_idle_next", 32'(drop_idle), 32'd1);
        check_events("drop", 0, 0, 0, 0);
        snap(); exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b0, 1, 1'b1, 1'b1, -100, 1'b0);
        check_events("after_drop", 1, 0, 0, 0);
        pop_check("after_drop_pop");

        // Async reset in mid-frame
        rx_line = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_busy", 32'(rx_sample_cnt_reset), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_idle", 32'(rx_sample_cnt_reset), 32'd1);
        rx_line = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        check("no_double_pulse", 32'(multi_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- FSM that sequences the UART receive datapath (synchronizer, sample shift register, parity calculator, bit/sample counters, error register, RX FIFO) to receive one 8N1/8E1/8O1/8N2 frame at a time.
- Arbitrates FIFO access between the frame writer and the bus-side reader.
- Emits one-cycle error pulses to the UART status/interrupt logic.

Parameters:
- none

Ports:
- clk in 1: system clock. One clock domain only.
- reset in 1: reset, asynchronous, active-high.
- baud_x16_tick in 1: one-clk strobe at 16x the baud rate.
- rx_enable in 1: receiver enable; low aborts the frame in progress.
- parity_en in 1: a parity bit follows the data bits.
- stop_bits_two in 1: two stop bits expected.
- rd_req in 1: bus-side request to pop one byte.
- rx_sync in 1: synchronized RX level.
- rx_sync_fall in 1: falling-edge strobe on the synchronized RX line.
- rx_get_sample in 1: sample counter value == 7 (mid-bit).
- rx_bits_cnt_top in 1: 8 data bits counted.
- rx_parity_out in 1: expected parity bit.
- rx_error_reg_out in 1: sticky parity error for the current frame.
- rx_queue_full in 1: FIFO full.
- rx_queue_empty in 1: FIFO empty.
- rx_sync_en out 1: synchronizer enable.
- rx_sample_reg_we out 1: shift register write enable.
- rx_sample_reg_reset out 1: shift register reset.
- rx_parity_we out 1: parity calculator write enable.
- rx_parity_reset out 1: parity calculator reset.
- rx_bits_cnt_en out 1: bit counter enable.
- rx_bits_cnt_reset out 1: bit counter reset.
- rx_sample_cnt_en out 1: sample counter enable.
- rx_sample_cnt_reset out 1: sample counter reset.
- rx_error_reg_set out 1: error register set.
- rx_error_reg_reset out 1: error register reset.
- rx_queue_we out 1: FIFO write enable.
- rx_queue_re out 1: FIFO read enable.
- frame_err out 1: registered one-clk pulse.
- parity_err out 1: registered one-clk pulse.
- overrun_err out 1: registered one-clk pulse.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, STORE. Only the state and the three error pulses are registered. All datapath controls are combinational from state and inputs.
- Reset: state=IDLE. frame_err=parity_err=overrun_err=0.
- Defining sample = baud_x16_tick & rx_get_sample. This is exactly one clk per bit period, at mid-bit.
- rx_sync_en=1 in every state.
- rx_queue_re = rd_req & ~rx_queue_empty in every state. Reads and writes may occur in the same cycle; the FIFO handles this.
- rx_sample_cnt_en = baud_x16_tick in every state except IDLE.
- IDLE outputs: all resets asserted (sample_cnt, bits_cnt, parity, sample_reg, error_reg).
- IDLE transition: rx_enable & rx_sync_fall -> START. The counters leave reset on the next clk, so the first sample lands 8 ticks after the fall.
- START: on sample, rx_sync=0 -> DATA. On sample, rx_sync=1 is a false start -> IDLE with no error.
- DATA, on sample: rx_sample_reg_we, rx_parity_we and rx_bits_cnt_en are all asserted for that one clk. The shift register shifts LSB-first.
- DATA, on rx_bits_cnt_top high (in any cycle): -> PARITY if parity_en, otherwise -> STOP1. This transition is taken before the next sample.
- PARITY: on sample, if rx_sync != rx_parity_out, assert rx_error_reg_set. -> STOP1 in either case.
- STOP1, on sample with rx_sync=0: frame_err pulses next clk -> IDLE. The frame is discarded. A held-low break does not retrigger, because IDLE waits for a fall.
- STOP1, on sample with rx_sync=1: -> STOP2 if stop_bits_two, otherwise -> STORE.
- STOP2: same rules as STOP1, but success always goes -> STORE.
- STORE (one clk, then -> IDLE):
  - rx_error_reg_out=1: parity_err pulses, no write.
  - Otherwise, rx_queue_full=1: overrun_err pulses, byte dropped.
  - Otherwise: rx_queue_we=1 for exactly one clk.
- rx_enable low in any non-IDLE state: -> IDLE next clk. No write, no error pulses.
- Async reset mid-frame: immediate return to IDLE. Pulses cleared. The FIFO is reset by its own port.
- No two error pulses are ever asserted in the same cycle.

Test Plan:
- Tick every clk, parity off, 1 stop bit, frame 0xA5 -> exactly one rx_queue_we. The FIFO then pops 0xA5 on rd_req. No error pulses.
- parity_en=1, even parity, 0x3C sent with parity bit 1 (wrong) -> parity_err pulses once. No rx_queue_we.
- Frame 0x55 with stop bit 0 -> frame_err pulses once, state IDLE. A continued low line causes no new START.
- 2-clk low glitch (< 8 ticks) -> START, then back to IDLE at mid-start. No write, no errors.
- FIFO full (16 entries) plus a valid frame 0x81 -> overrun_err pulses once. FIFO contents unchanged. A simultaneous rd_req in STORE still pops.
- rx_enable dropped during the 4th data bit -> IDLE next clk. No write or error. The next valid frame 0x0F is stored correctly.
